// File: rtl/code_pkg.sv
// ============================================================================
// Module : code_pkg
// Brief  : Shared constants and state type for the code entry loader path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package code_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int CODE_W     = NUM_DIGITS * DIGIT_W;
  localparam int BCD_MAX    = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/code_shift_reg.sv
// ============================================================================
// Module : code_shift_reg
// Brief  : Digit-wide, NUM_DIGITS-deep shift buffer; newest digit enters at LSBs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module code_shift_reg #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          load,
  input  logic                          first,
  input  logic [DIGIT_W-1:0]            digit,
  output logic [NUM_DIGITS*DIGIT_W-1:0] data
);

  import code_pkg::*;

  logic [NUM_DIGITS*DIGIT_W-1:0] r_data;
  logic [NUM_DIGITS*DIGIT_W-1:0] w_next;

  // Slot 0 takes the new digit; older slots shift up unless this is the
  // first digit of an entry, in which case stale digits are dropped.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsb
      assign w_next[DIGIT_W-1:0] = digit;
    end else begin : g_upper
      assign w_next[i*DIGIT_W +: DIGIT_W] =
        first ? '0 : r_data[(i-1)*DIGIT_W +: DIGIT_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (clear) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= w_next;
    end
  end

  assign data = r_data;

endmodule

`default_nettype wire

// File: rtl/code_entry_loader.sv
// ============================================================================
// Module : code_entry_loader
// Brief  : Collects BCD keypad digits into a code; commits to comparator or store.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module code_entry_loader #(
  parameter int                              NUM_DIGITS = 4,
  parameter int                              DIGIT_W    = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]   RESET_CODE = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               key_valid,
  input  logic [DIGIT_W-1:0]                 key_digit,
  input  logic                               key_enter,
  input  logic                               key_clear,
  input  logic                               prog_mode,
  output logic [NUM_DIGITS*DIGIT_W-1:0]      entry_code,
  output logic [NUM_DIGITS*DIGIT_W-1:0]      stored_code,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    entry_count,
  output logic                               entry_ready,
  output logic                               store_done,
  output logic                               entry_err
);

  import code_pkg::*;

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int BUF_W = NUM_DIGITS * DIGIT_W;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt, w_count_inc;
  logic [BUF_W-1:0]   r_stored;
  logic               r_ready, r_done, r_err;
  logic               w_ready_nxt, w_done_nxt, w_err_nxt;
  logic               w_sr_load, w_sr_first, w_sr_clear, w_store;
  logic [BUF_W-1:0]   w_buf;

  code_shift_reg #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_sr_clear),
    .load  (w_sr_load),
    .first (w_sr_first),
    .digit (key_digit),
    .data  (w_buf)
  );

  assign w_count_inc = r_count + 1'b1;

  // Only the highest-priority strobe acts: clear, then enter, then digit.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_sr_load   = 1'b0;
    w_sr_first  = 1'b0;
    w_sr_clear  = 1'b0;
    w_store     = 1'b0;
    w_ready_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    if (key_clear) begin
      w_sr_clear  = 1'b1;
      w_count_nxt = '0;
      w_state_nxt = ST_IDLE;
    end else if (key_enter) begin
      w_count_nxt = '0;
      w_state_nxt = ST_IDLE;
      if (r_state == ST_FULL) begin
        if (prog_mode) begin
          // Stored copy takes the pre-clear buffer on the same edge.
          w_store    = 1'b1;
          w_done_nxt = 1'b1;
          w_sr_clear = 1'b1;
        end else begin
          w_ready_nxt = 1'b1;
        end
      end else begin
        w_err_nxt  = 1'b1;
        w_sr_clear = 1'b1;
      end
    end else if (key_valid) begin
      if (key_digit > DIGIT_W'(BCD_MAX)) begin
        w_err_nxt = 1'b1;
      end else if (r_state != ST_FULL) begin
        w_sr_load   = 1'b1;
        w_sr_first  = (r_state == ST_IDLE);
        w_count_nxt = w_count_inc;
        w_state_nxt = (w_count_inc == CNT_W'(NUM_DIGITS)) ? ST_FULL : ST_COLLECT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_stored <= RESET_CODE;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_ready  <= w_ready_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      if (w_store) begin
        r_stored <= w_buf;
      end
    end
  end

  assign entry_code  = w_buf;
  assign stored_code = r_stored;
  assign entry_count = r_count;
  assign entry_ready = r_ready;
  assign store_done  = r_done;
  assign entry_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_code_entry_loader.sv
// ============================================================================
// Module : tb_code_entry_loader
// Brief  : Directed and randomized checks of code_entry_loader against a digit-queue model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_code_entry_loader;

  localparam int NUM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        key_enter = 1'b0;
  logic        key_clear = 1'b0;
  logic        prog_mode = 1'b0;
  logic [15:0] entry_code;
  logic [15:0] stored_code;
  logic [2:0]  entry_count;
  logic        entry_ready;
  logic        store_done;
  logic        entry_err;

  int tests = 0;
  int fails = 0;

  // Reference model: the digits of the current entry, the displayed buffer
  // value, the stored code and the pulses expected after the last edge.
  int m_digits[$];
  int m_show;
  int m_stored;
  bit m_ready, m_done, m_err;

  always #5 clk = ~clk;

  code_entry_loader #(
    .NUM_DIGITS (4),
    .DIGIT_W    (4),
    .RESET_CODE (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .key_enter   (key_enter),
    .key_clear   (key_clear),
    .prog_mode   (prog_mode),
    .entry_code  (entry_code),
    .stored_code (stored_code),
    .entry_count (entry_count),
    .entry_ready (entry_ready),
    .store_done  (store_done),
    .entry_err   (entry_err)
  );

  task automatic model_reset();
    m_digits.delete();
    m_show   = 0;
    m_stored = 0;
    m_ready  = 0;
    m_done   = 0;
    m_err    = 0;
  endtask

  // Drive one cycle of strobes, then advance the model by the same rules.
  task automatic apply(input bit c, input bit e, input bit v, input int d, input bit p);
    @(negedge clk);
    key_clear = c;
    key_enter = e;
    key_valid = v;
    key_digit = 4'(d);
    prog_mode = p;
    @(posedge clk);
    #1;
    key_clear = 1'b0;
    key_enter = 1'b0;
    key_valid = 1'b0;
    m_ready = 0;
    m_done  = 0;
    m_err   = 0;
    if (c) begin
      m_digits.delete();
      m_show = 0;
    end else if (e) begin
      if (m_digits.size() == NUM) begin
        if (p) begin
          m_stored = m_show;
          m_done   = 1;
          m_show   = 0;
        end else begin
          m_ready = 1;
        end
      end else begin
        m_err  = 1;
        m_show = 0;
      end
      m_digits.delete();
    end else if (v) begin
      if (d > 9) begin
        m_err = 1;
      end else if (m_digits.size() < NUM) begin
        if (m_digits.size() == 0) m_show = 0;
        m_digits.push_back(d);
        m_show = ((m_show * 16) + d) % 65536;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    tests++; if (entry_code !== 16'h0000) begin fails++; $display("FAIL reset_entry_code got=%h exp=0000", entry_code); end
    tests++; if (stored_code !== 16'h0000) begin fails++; $display("FAIL reset_stored_code got=%h exp=0000", stored_code); end
    tests++; if (entry_count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", entry_count); end
    tests++; if ({entry_ready, store_done, entry_err} !== 3'b000) begin
      fails++; $display("FAIL reset_pulses got=%b exp=000", {entry_ready, store_done, entry_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal_entry();
    apply(0, 0, 1, 1, 0); apply(0, 0, 1, 2, 0); apply(0, 0, 1, 3, 0); apply(0, 0, 1, 4, 0);
    tests++; if (entry_code !== 16'h1234) begin fails++; $display("FAIL normal_code got=%h exp=1234", entry_code); end
    tests++; if (entry_count !== 3'd4) begin fails++; $display("FAIL normal_count got=%0d exp=4", entry_count); end
    apply(0, 1, 0, 0, 0);
    tests++; if (entry_ready !== 1'b1) begin fails++; $display("FAIL normal_ready got=%b exp=1", entry_ready); end
    tests++; if (entry_count !== 3'd0) begin fails++; $display("FAIL normal_count_after got=%0d exp=0", entry_count); end
    tests++; if (entry_code !== 16'h1234) begin fails++; $display("FAIL normal_code_held got=%h exp=1234", entry_code); end
    apply(0, 0, 0, 0, 0);
    tests++; if (entry_ready !== 1'b0) begin fails++; $display("FAIL normal_ready_width got=%b exp=0", entry_ready); end
  endtask

  task automatic test_program();
    apply(0, 0, 1, 9, 1); apply(0, 0, 1, 8, 1); apply(0, 0, 1, 7, 1); apply(0, 0, 1, 6, 1);
    apply(0, 1, 0, 0, 1);
    tests++; if (stored_code !== 16'h9876) begin fails++; $display("FAIL prog_stored got=%h exp=9876", stored_code); end
    tests++; if (store_done !== 1'b1) begin fails++; $display("FAIL prog_done got=%b exp=1", store_done); end
    tests++; if (entry_code !== 16'h0000) begin fails++; $display("FAIL prog_entry_zero got=%h exp=0000", entry_code); end
    tests++; if (entry_ready !== 1'b0) begin fails++; $display("FAIL prog_no_ready got=%b exp=0", entry_ready); end
    apply(0, 0, 0, 0, 0);
    tests++; if (store_done !== 1'b0) begin fails++; $display("FAIL prog_done_width got=%b exp=0", store_done); end
  endtask

  task automatic test_short_enter();
    apply(0, 0, 1, 5, 0); apply(0, 0, 1, 5, 0);
    apply(0, 1, 0, 0, 0);
    tests++; if (entry_err !== 1'b1) begin fails++; $display("FAIL short_err got=%b exp=1", entry_err); end
    tests++; if (entry_code !== 16'h0000) begin fails++; $display("FAIL short_code got=%h exp=0000", entry_code); end
    tests++; if (entry_ready !== 1'b0) begin fails++; $display("FAIL short_no_ready got=%b exp=0", entry_ready); end
    apply(0, 0, 0, 0, 0);
    tests++; if (entry_err !== 1'b0) begin fails++; $display("FAIL short_err_width got=%b exp=0", entry_err); end
  endtask

  task automatic test_bad_digit();
    apply(0, 0, 1, 3, 0);
    apply(0, 0, 1, 12, 0);
    tests++; if (entry_err !== 1'b1) begin fails++; $display("FAIL bad_err got=%b exp=1", entry_err); end
    tests++; if (entry_count !== 3'd1) begin fails++; $display("FAIL bad_count got=%0d exp=1", entry_count); end
    tests++; if (entry_code !== 16'h0003) begin fails++; $display("FAIL bad_code got=%h exp=0003", entry_code); end
    apply(1, 0, 0, 0, 0);
  endtask

  task automatic test_fifth_digit();
    apply(0, 0, 1, 1, 0); apply(0, 0, 1, 2, 0); apply(0, 0, 1, 3, 0); apply(0, 0, 1, 4, 0);
    apply(0, 0, 1, 7, 0);
    tests++; if (entry_code !== 16'h1234) begin fails++; $display("FAIL fifth_code got=%h exp=1234", entry_code); end
    tests++; if (entry_count !== 3'd4) begin fails++; $display("FAIL fifth_count got=%0d exp=4", entry_count); end
    tests++; if (entry_err !== 1'b0) begin fails++; $display("FAIL fifth_no_err got=%b exp=0", entry_err); end
  endtask

  task automatic test_clear_priority();
    apply(1, 1, 0, 0, 0);
    tests++; if (entry_code !== 16'h0000) begin fails++; $display("FAIL clr_code got=%h exp=0000", entry_code); end
    tests++; if (entry_count !== 3'd0) begin fails++; $display("FAIL clr_count got=%0d exp=0", entry_count); end
    tests++; if ({entry_ready, store_done, entry_err} !== 3'b000) begin
      fails++; $display("FAIL clr_pulses got=%b exp=000", {entry_ready, store_done, entry_err});
    end
    tests++; if (stored_code !== 16'h9876) begin fails++; $display("FAIL clr_stored got=%h exp=9876", stored_code); end
  endtask

  task automatic test_reset_mid_entry();
    apply(0, 0, 1, 2, 0); apply(0, 0, 1, 2, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    tests++; if (entry_count !== 3'd0) begin fails++; $display("FAIL midrst_count got=%0d exp=0", entry_count); end
    tests++; if (stored_code !== 16'h0000) begin fails++; $display("FAIL midrst_stored got=%h exp=0000", stored_code); end
    tests++; if (entry_code !== 16'h0000) begin fails++; $display("FAIL midrst_code got=%h exp=0000", entry_code); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      bit c, e, v, p;
      int d;
      c = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 3) != 0);
      p = $urandom_range(0, 1);
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      apply(c, e, v, d, p);
      tests++;
      if ({entry_code, stored_code, entry_count, entry_ready, store_done, entry_err} !==
          {16'(m_show), 16'(m_stored), 3'(m_digits.size()), m_ready, m_done, m_err}) begin
        fails++;
        $display("FAIL random_step%0d got code=%h stored=%h cnt=%0d rdy=%b done=%b err=%b exp code=%h stored=%h cnt=%0d rdy=%b done=%b err=%b",
                 n, entry_code, stored_code, entry_count, entry_ready, store_done, entry_err,
                 16'(m_show), 16'(m_stored), m_digits.size(), m_ready, m_done, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_entry();
    test_program();
    test_short_enter();
    test_bad_digit();
    test_fifth_digit();
    test_clear_priority();
    test_reset_mid_entry();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
